redmule_mx_encoder: RTL

//  Converts a stream of FP16 values into MXFP8 blocks: FP8 E4M3 elements sharing one E8M0 scale.

---
 rtl/redmule_mx_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/redmule_mx_encoder.sv
// redmule_mx_encoder: packs an FP16 stream into MXFP8 blocks (E4M3 elements + shared E8M0 scale).
// Optional MX_ENC_RNE_EN rounds mantissas to nearest-even; otherwise they are truncated.
module redmule_mx_encoder #(
  parameter int DATA_W    = 256,
  parameter int BITW      = 16,
  parameter int NUM_LANES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      fp16_valid_i,
  output logic                      fp16_ready_o,
  input  logic [NUM_LANES*BITW-1:0] fp16_data_i,
  output logic                      mx_val_valid_o,
  input  logic                      mx_val_ready_i,
  output logic [DATA_W-1:0]         mx_val_data_o,
  output logic                      mx_exp_valid_o,
  input  logic                      mx_exp_ready_i,
  output logic [7:0]                mx_exp_data_o
);
  localparam int NUM_ELEMS  = DATA_W / 8;
  localparam int NUM_GROUPS = NUM_ELEMS / NUM_LANES;
  localparam int GW = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1;
  localparam int IW = NUM_ELEMS > 1 ? $clog2(NUM_ELEMS) : 1;
  localparam logic [GW-1:0] LAST = GW'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {COLLECT, SCALE, ENCODE, EMIT} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q;
  logic [4:0]      max_q, max_d;
  logic [BITW-1:0] blk_q [NUM_ELEMS];
  logic [7:0]      val_q [NUM_ELEMS];
  logic [7:0]      exp_q;
  logic            val_done_q, exp_done_q;
  logic [4:0]      lane_e [NUM_LANES];
  logic            in_hs, val_hs, exp_hs, last_g, emit_done;

  // The block max maps to E4M3 biased exponent 14; anything 14+ binades below flushes.
  function automatic logic [7:0] enc(logic [15:0] x, logic [4:0] mx);
    logic [6:0] e8;
    logic [3:0] m8;
    e8 = 7'(x[14:10]) - 7'(mx) + 7'd14;
    m8 = {1'b0, x[9:7]};
`ifdef MX_ENC_RNE_EN
    m8 = m8 + 4'(x[6] & ((|x[5:0]) | x[7]));
`endif
    if (x[14:10] == 5'd0) return {x[15], 7'd0};
    if (x[14:10] == 5'd31) return {x[15], 4'hF, 2'b00, |x[9:0]};
    if ($signed(e8) <= 7'sd0) return {x[15], 7'd0};
    e8 = e8 + 7'(m8[3]);
    if (e8 >= 7'd15) return {x[15], 4'hE, 3'h7};
    return {x[15], e8[3:0], m8[2:0]};
  endfunction

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_e[l] = fp16_data_i[BITW*l+10 +: 5];
  end

  for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_out
    assign mx_val_data_o[8*i +: 8] = val_q[i];
  end

  assign fp16_ready_o   = state_q == COLLECT;
  assign mx_val_valid_o = state_q == EMIT && !val_done_q;
  assign mx_exp_valid_o = state_q == EMIT && !exp_done_q;
  assign mx_exp_data_o  = exp_q;
  assign in_hs     = fp16_valid_i & fp16_ready_o;
  assign val_hs    = mx_val_valid_o & mx_val_ready_i;
  assign exp_hs    = mx_exp_valid_o & mx_exp_ready_i;
  assign emit_done = (val_done_q | val_hs) & (exp_done_q | exp_hs);
  assign last_g    = g_q == LAST;

  always_comb begin
    max_d = max_q;
    for (int l = 0; l < NUM_LANES; l++)
      max_d = (lane_e[l] != 5'd0 && lane_e[l] != 5'd31 && lane_e[l] > max_d) ? lane_e[l] : max_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: state_d = (in_hs && last_g) ? SCALE : COLLECT;
      SCALE:   state_d = ENCODE;
      ENCODE:  state_d = last_g ? EMIT : ENCODE;
      EMIT:    state_d = emit_done ? COLLECT : EMIT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i)
    if (in_hs)
      for (int l = 0; l < NUM_LANES; l++)
        blk_q[IW'(int'(g_q) * NUM_LANES + l)] <= fp16_data_i[BITW*l +: BITW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= COLLECT;
      g_q        <= '0;
      max_q      <= '0;
      exp_q      <= '0;
      val_done_q <= 1'b0;
      exp_done_q <= 1'b0;
      for (int i = 0; i < NUM_ELEMS; i++) val_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        COLLECT: if (in_hs) begin
          g_q   <= last_g ? '0 : g_q + 1'b1;
          max_q <= max_d;
        end
        SCALE: begin
          exp_q <= max_q == 5'd0 ? 8'd127 : 8'(max_q) + 8'd105;
          g_q   <= '0;
        end
        ENCODE: begin
          for (int l = 0; l < NUM_LANES; l++)
            val_q[IW'(int'(g_q) * NUM_LANES + l)] <= enc(blk_q[IW'(int'(g_q) * NUM_LANES + l)], max_q);
          g_q <= last_g ? '0 : g_q + 1'b1;
        end
        EMIT: begin
          val_done_q <= emit_done ? 1'b0 : val_done_q | val_hs;
          exp_done_q <= emit_done ? 1'b0 : exp_done_q | exp_hs;
          if (emit_done) begin
            max_q <= '0;
            g_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
